pc_stack_ctrl: RTL and testbench
================================

# pc_stack_ctrl

Program-counter sequencer and hardware call stack for the MCU core. It takes the decoded control-flow operation for the current instruction (next, GOTO, CALL, RETURN) and produces the next fetch address. It manages a circular return-address stack and inserts the one-cycle pipeline flush after every taken branch, so GOTO, CALL and RETURN execute as two-cycle instructions. It sits between the instruction decoder and program memory inside the CPU.

## Interface
- PC_W, 11, program counter / program memory address width
- DEPTH, 8, return-stack entries (power of two, ≥2)
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- op  input  2  control-flow op: 00 NEXT, 01 GOTO, 10 CALL, 11 RETURN
- op_valid  input  1  op/target valid this cycle
- target  input  PC_W  branch/call destination
- stall  input  1  freeze all state this cycle
- err_clr  input  1  clear sticky overflow/underflow
- pc  output  PC_W  current fetch address (registered)
- fetch_en  output  1  program memory read enable
- flush  output  1  instruction fetched this cycle is discarded (execute as NOP)
- stack_depth  output  $clog2(DEPTH+1)  valid stack entries, 0..DEPTH
- overflow  output  1  sticky: CALL with stack full
- underflow  output  1  sticky: RETURN with stack empty

## Operation
- Reset (reset=0, asynchronous): pc=0, state=RUN, stack pointer=0, stack_depth=0, flush=0, overflow=0, underflow=0, fetch_en=0. Stack RAM contents are not reset.
- fetch_en = reset deasserted AND ~stall (combinational).
- FSM states: RUN, FLUSH. flush=1 exactly when state=FLUSH.
- RUN, stall=0:
  - op_valid=0 or NEXT: pc←pc+1, stay RUN.
  - GOTO: pc←target, go FLUSH.
  - CALL: mem[sp]←pc+1, sp←sp+1 mod DEPTH, pc←target, go FLUSH. stack_depth+1, saturating at DEPTH.
  - RETURN: pc←mem[sp−1 mod DEPTH], sp←sp−1 mod DEPTH, go FLUSH. stack_depth−1, saturating at 0.
- FLUSH, stall=0: op/op_valid ignored. pc←pc+1, go RUN.
- stall=1 in either state: pc, state, sp, stack_depth and the stack all hold. Sticky flags still honour err_clr.
- Overflow: CALL at stack_depth==DEPTH.
  - Push still occurs and overwrites the oldest entry (circular).
  - stack_depth stays DEPTH; overflow←1.
- Underflow: RETURN at stack_depth==0.
  - Pop still occurs (pc loads the stale circular entry, sp decrements).
  - stack_depth stays 0; underflow←1.
- Arithmetic: pc+1 wraps modulo 2^PC_W (all-ones → 0). The pushed return address pc+1 wraps the same way.
- err_clr=1 clears overflow/underflow. If err_clr coincides with a new error event, the flag is set (set wins).

## Timing
- All outputs except fetch_en are registered. Each op takes effect on pc one cycle after it is sampled.
- A branch op sampled in RUN at edge N gives pc=target (or the return address) after N, with flush=1 for that cycle. The cycle after that has flush=0 and pc=target+1.
- Minimum spacing between branches is 2 cycles; an op sampled during FLUSH is lost by design.
- Stack push and pop complete in the same edge as the pc update. stack_depth is updated on that same edge.
- Reset asserted mid-FLUSH or mid-stall returns to RUN with pc=0 immediately (asynchronous). The first fetch after release is address 0.

## Test plan
- Reset, then 5 cycles with op_valid=0 → pc steps 0,1,2,3,4,5; flush=0; fetch_en=1 after reset release.
- At pc=3, GOTO target=0x100 → next cycle pc=0x100 with flush=1, then pc=0x101 with flush=0. An op presented during the flush cycle is ignored.
- At pc=0x010, CALL 0x200 → stack_depth=1 and pc=0x200 with flush. Two NEXTs, then RETURN → pc=0x011 with flush=1, stack_depth=0.
- 9 nested CALLs with DEPTH=8 → overflow=1 after the 9th and stack_depth=8. Then 8 RETURNs pop return addresses of calls 9..2, in that order. A 9th RETURN → underflow=1, stack_depth=0. err_clr → both flags 0.
- Set pc=0x7FF (GOTO 0x7FF), then NEXT ×2 → pc 0x000 then 0x001. CALL from pc=0x7FF pushes 0x000.
- Hold stall=1 for 3 cycles during FLUSH → pc, flush and stack_depth frozen and fetch_en=0; sequence resumes unchanged afterward. Assert reset mid-stall → pc=0, flush=0 immediately.

Source files
------------

// File: rtl/pc_stack_ctrl_if.sv
// Control-flow bus between the instruction decoder (master) and the PC sequencer (slave).
interface pc_stack_ctrl_if #(
    parameter int unsigned PC_W  = 11,
    parameter int unsigned DEPTH = 8
);
    logic [1:0]                     op;
    logic                           op_valid;
    logic [PC_W-1:0]                target;
    logic                           stall;
    logic                           err_clr;
    logic [PC_W-1:0]                pc;
    logic                           fetch_en;
    logic                           flush;
    logic [$clog2(DEPTH+1)-1:0]     stack_depth;
    logic                           overflow;
    logic                           underflow;

    modport master (
        output op, op_valid, target, stall, err_clr,
        input  pc, fetch_en, flush, stack_depth, overflow, underflow
    );

    modport slave (
        input  op, op_valid, target, stall, err_clr,
        output pc, fetch_en, flush, stack_depth, overflow, underflow
    );
endinterface

// File: rtl/pc_stack_ctrl.sv
// Program-counter sequencer with circular return-address stack; every taken
// branch is followed by one flush cycle.
module pc_stack_ctrl #(
    parameter int unsigned PC_W  = 11,
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    pc_stack_ctrl_if.slave bus
);
    localparam int unsigned SP_W = $clog2(DEPTH);
    localparam int unsigned DW   = $clog2(DEPTH + 1);

    localparam logic [1:0] OpNext = 2'b00;
    localparam logic [1:0] OpGoto = 2'b01;
    localparam logic [1:0] OpCall = 2'b10;
    localparam logic [1:0] OpRet  = 2'b11;

    typedef enum logic {StRun, StFlush} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic [SP_W-1:0] sp_q, sp_d, sp_dec;
    logic [DW-1:0]   depth_q, depth_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            push, ovf_evt, unf_evt, full, empty;
    logic [PC_W-1:0] mem [DEPTH];

    assign pc_inc = pc_q + PC_W'(1);
    assign sp_dec = sp_q - SP_W'(1);
    assign full   = (depth_q == DW'(DEPTH));
    assign empty  = (depth_q == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        push    = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (!bus.stall) begin
            unique case (state_q)
                StFlush: begin
                    pc_d    = pc_inc;
                    state_d = StRun;
                end
                StRun: begin
                    pc_d = pc_inc;
                    if (bus.op_valid) begin
                        unique case (bus.op)
                            OpNext: ;
                            OpGoto: begin
                                pc_d    = bus.target;
                                state_d = StFlush;
                            end
                            OpCall: begin
                                // A full stack still pushes, overwriting the oldest entry.
                                push    = 1'b1;
                                sp_d    = sp_q + SP_W'(1);
                                pc_d    = bus.target;
                                state_d = StFlush;
                                if (full) ovf_evt = 1'b1;
                                else      depth_d = depth_q + DW'(1);
                            end
                            OpRet: begin
                                // An empty stack still pops the stale circular entry.
                                sp_d    = sp_dec;
                                pc_d    = mem[sp_dec];
                                state_d = StFlush;
                                if (empty) unf_evt = 1'b1;
                                else       depth_d = depth_q - DW'(1);
                            end
                        endcase
                    end
                end
            endcase
        end
        ovf_d = (ovf_q & ~bus.err_clr) | ovf_evt;
        unf_d = (unf_q & ~bus.err_clr) | unf_evt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            pc_q    <= '0;
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[sp_q] <= pc_inc;
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_en    = reset & ~bus.stall;
    assign bus.flush       = (state_q == StFlush);
    assign bus.stack_depth = depth_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Directed and random checks of pc_stack_ctrl against a behavioural model of
// the PC sequence and the circular return stack.
module tb_pc_stack_ctrl;
    localparam int PC_W  = 11;
    localparam int DEPTH = 8;
    localparam int PC_MOD = 1 << PC_W;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int mpc, msp, mdepth;
    bit mflush, movf, munf;
    int mmem [DEPTH];

    pc_stack_ctrl_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    pc_stack_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        mpc = 0; msp = 0; mdepth = 0; mflush = 0; movf = 0; munf = 0;
    endfunction

    function automatic void model_edge(input int o, input bit v, input int t, input bit s,
                                       input bit c);
        bit ovf_evt = 0;
        bit unf_evt = 0;
        if (!s) begin
            if (mflush || !v || o == 0) begin
                mpc = (mpc + 1) % PC_MOD;
                mflush = 0;
            end else if (o == 1) begin
                mpc = t;
                mflush = 1;
            end else if (o == 2) begin
                ovf_evt = (mdepth == DEPTH);
                mmem[msp] = (mpc + 1) % PC_MOD;
                msp = (msp + 1) % DEPTH;
                if (mdepth < DEPTH) mdepth++;
                mpc = t;
                mflush = 1;
            end else begin
                unf_evt = (mdepth == 0);
                msp = (msp + DEPTH - 1) % DEPTH;
                mpc = mmem[msp];
                if (mdepth > 0) mdepth--;
                mflush = 1;
            end
        end
        movf = (movf && !c) || ovf_evt;
        munf = (munf && !c) || unf_evt;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    32'(bus.pc),          32'(mpc));
        chk({tag, ".flush"}, 32'(bus.flush),       32'(mflush));
        chk({tag, ".depth"}, 32'(bus.stack_depth), 32'(mdepth));
        chk({tag, ".ovf"},   32'(bus.overflow),    32'(movf));
        chk({tag, ".unf"},   32'(bus.underflow),   32'(munf));
        chk({tag, ".fe"},    32'(bus.fetch_en),    32'(reset & ~bus.stall));
    endtask

    task automatic step(input logic [1:0] o, input logic v, input int t, input logic s,
                        input logic c, input string tag);
        bus.op = o; bus.op_valid = v; bus.target = PC_W'(t); bus.stall = s; bus.err_clr = c;
        @(posedge clk);
        model_edge(int'(o), v, t, s, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        bus.op = 2'b00; bus.op_valid = 1'b0; bus.target = '0; bus.stall = 1'b0;
        bus.err_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = 0;
        model_reset();
        #3;
        check_all("reset");
        chk("reset.fe0", 32'(bus.fetch_en), 32'd0);
        #9;
        reset = 1'b1;
        #1;
        check_all("release");
        chk("release.fe1", 32'(bus.fetch_en), 32'd1);

        // Sequential fetch, then GOTO with an op offered during the flush cycle
        for (int i = 1; i <= 3; i++) begin
            step(2'b00, 1'b0, 0, 1'b0, 1'b0, "next");
            chk("next.const", 32'(bus.pc), 32'(i));
        end
        step(2'b01, 1'b1, 'h100, 1'b0, 1'b0, "goto");
        chk("goto.pc", 32'(bus.pc), 32'h100);
        chk("goto.flush", 32'(bus.flush), 32'd1);
        step(2'b10, 1'b1, 'h300, 1'b0, 1'b0, "goto_ign");
        chk("goto_ign.pc", 32'(bus.pc), 32'h101);
        chk("goto_ign.depth", 32'(bus.stack_depth), 32'd0);

        // CALL from 0x010, two NEXTs, RETURN
        step(2'b01, 1'b1, 'h00f, 1'b0, 1'b0, "to10");
        step(2'b00, 1'b1, 0, 1'b0, 1'b0, "to10f");
        step(2'b10, 1'b1, 'h200, 1'b0, 1'b0, "call");
        chk("call.depth", 32'(bus.stack_depth), 32'd1);
        step(2'b00, 1'b1, 0, 1'b0, 1'b0, "call_f");
        step(2'b00, 1'b1, 0, 1'b0, 1'b0, "call_n1");
        step(2'b00, 1'b1, 0, 1'b0, 1'b0, "call_n2");
        step(2'b11, 1'b1, 0, 1'b0, 1'b0, "ret");
        chk("ret.pc", 32'(bus.pc), 32'h011);
        chk("ret.depth", 32'(bus.stack_depth), 32'd0);
        step(2'b00, 1'b0, 0, 1'b0, 1'b0, "ret_f");

        // Nine nested calls overflow an 8-deep stack
        for (int j = 1; j <= 9; j++) begin
            step(2'b10, 1'b1, 'h400 + j * 16, 1'b0, 1'b0, "ncall");
            step(2'b00, 1'b0, 0, 1'b0, 1'b0, "ncall_f");
        end
        chk("nest.ovf", 32'(bus.overflow), 32'd1);
        chk("nest.depth", 32'(bus.stack_depth), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            step(2'b11, 1'b1, 0, 1'b0, 1'b0, "nret");
            chk("nret.pc", 32'(bus.pc), 32'('h400 + (9 - k) * 16 + 2));
            step(2'b00, 1'b0, 0, 1'b0, 1'b0, "nret_f");
        end
        step(2'b11, 1'b1, 0, 1'b0, 1'b0, "uret");
        chk("uret.unf", 32'(bus.underflow), 32'd1);
        chk("uret.depth", 32'(bus.stack_depth), 32'd0);
        step(2'b00, 1'b0, 0, 1'b0, 1'b1, "clr");
        chk("clr.flags", 32'({bus.overflow, bus.underflow}), 32'd0);

        // PC wrap and wrapped return address
        step(2'b01, 1'b1, 'h7ff, 1'b0, 1'b0, "wrap_goto");
        step(2'b00, 1'b1, 0, 1'b0, 1'b0, "wrap_n1");
        chk("wrap.pc0", 32'(bus.pc), 32'h000);
        step(2'b00, 1'b1, 0, 1'b0, 1'b0, "wrap_n2");
        chk("wrap.pc1", 32'(bus.pc), 32'h001);
        step(2'b01, 1'b1, 'h7fe, 1'b0, 1'b0, "wc_goto");
        step(2'b00, 1'b1, 0, 1'b0, 1'b0, "wc_f");
        step(2'b10, 1'b1, 'h050, 1'b0, 1'b0, "wc_call");
        step(2'b00, 1'b1, 0, 1'b0, 1'b0, "wc_callf");
        step(2'b11, 1'b1, 0, 1'b0, 1'b0, "wc_ret");
        chk("wc_ret.pc", 32'(bus.pc), 32'h000);
        step(2'b00, 1'b1, 0, 1'b0, 1'b0, "wc_retf");

        // Stall during FLUSH
        step(2'b01, 1'b1, 'h123, 1'b0, 1'b0, "st_goto");
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 1'b1, 'h555, 1'b1, 1'b0, "stall");
            chk("stall.pc", 32'(bus.pc), 32'h123);
            chk("stall.flush", 32'(bus.flush), 32'd1);
            chk("stall.fe", 32'(bus.fetch_en), 32'd0);
        end
        step(2'b00, 1'b0, 0, 1'b0, 1'b0, "unstall");
        chk("unstall.pc", 32'(bus.pc), 32'h124);

        // Reset asserted mid-stall during FLUSH
        step(2'b01, 1'b1, 'h2aa, 1'b0, 1'b0, "rs_goto");
        step(2'b00, 1'b0, 0, 1'b1, 1'b0, "rs_stall");
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rs_mid");
        chk("rs_mid.pc", 32'(bus.pc), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.stall = 1'b0;
        #1;
        check_all("rs_rel");

        // Underflow coinciding with err_clr: set wins
        step(2'b11, 1'b1, 0, 1'b0, 1'b1, "set_wins");
        chk("set_wins.unf", 32'(bus.underflow), 32'd1);
        step(2'b00, 1'b0, 0, 1'b0, 1'b1, "set_wins_clr");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, PC_MOD - 1)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
